// File: rtl/useq.sv
// ----------------------------------------------------------------------------
// useq : microsequencer for the uProgram ROM.
//
// Holds the micro-PC (uaddr) and executes the sequencing field of the
// microword the ROM presents: NEXT, JUMP, CJMP, CALL, RET, DISPATCH, WAIT and
// HALT. Return addresses live on a small LIFO stack. uaddr is registered on
// posedge clk. The ROM reads it on the following negedge, so one
// microinstruction executes per clock.
//
// Optional feature (macro UPGM_LOAD_EN): adds a ROM load path
// (load_req/load_addr/load_data) and a LOAD state. In LOAD the sequencer
// drives ROM write address, enable and data. Without the macro, upgm_we and
// upgm_wdata are tied to zero.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   seq_op          sequencing opcode of the current microword
//   seq_target      branch/call target of the current microword
//   seq_cond_sel    index into cond
//   seq_cond_inv    invert the selected condition
//   cond            live datapath condition flags
//   dispatch_addr   entry address from the opcode map
//   stall           hold the sequencer (ignored in HALT)
//   restart         leave HALT
//   uaddr           micro-address to the ROM
//   upgm_we         ROM write enable
//   upgm_wdata      ROM write data
//   halted          high while halted
//   stack_err       sticky stack overflow/underflow flag
//   load_req/load_addr/load_data  (UPGM_LOAD_EN only) ROM load interface
// ----------------------------------------------------------------------------
module useq #(
  parameter int UADDR_W     = 10,
  parameter int STACK_DEPTH = 4,
  parameter int NCOND       = 16,
  parameter int RESET_VEC   = 0,
  parameter int UPGM_W      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               seq_op,
  input  logic [UADDR_W-1:0]       seq_target,
  input  logic [$clog2(NCOND)-1:0] seq_cond_sel,
  input  logic                     seq_cond_inv,
  input  logic [NCOND-1:0]         cond,
  input  logic [UADDR_W-1:0]       dispatch_addr,
  input  logic                     stall,
  input  logic                     restart,
`ifdef UPGM_LOAD_EN
  input  logic                     load_req,
  input  logic [UADDR_W-1:0]       load_addr,
  input  logic [UPGM_W-1:0]        load_data,
`endif
  output logic [UADDR_W-1:0]       uaddr,
  output logic                     upgm_we,
  output logic [UPGM_W-1:0]        upgm_wdata,
  output logic                     halted,
  output logic                     stack_err
);

  // sp ranges 0..STACK_DEPTH inclusive, so it needs one more code than the
  // stack index does.
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [UADDR_W-1:0] RESET_ADDR = UADDR_W'(RESET_VEC);
  localparam logic [SP_W-1:0]    SP_FULL    = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0]    SP_EMPTY   = '0;
  localparam logic [SP_W-1:0]    SP_ONE     = SP_W'(1);
  localparam logic [UADDR_W-1:0] ADDR_ONE   = UADDR_W'(1);

  localparam logic [2:0] OP_NEXT     = 3'd0;
  localparam logic [2:0] OP_JUMP     = 3'd1;
  localparam logic [2:0] OP_CJMP     = 3'd2;
  localparam logic [2:0] OP_CALL     = 3'd3;
  localparam logic [2:0] OP_RET      = 3'd4;
  localparam logic [2:0] OP_DISPATCH = 3'd5;
  localparam logic [2:0] OP_WAIT     = 3'd6;
  localparam logic [2:0] OP_HALT     = 3'd7;

  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_LOAD  = 2'd3
  } state_t;

  state_t               state_q;
  logic [UADDR_W-1:0]   uaddr_q;
  logic [SP_W-1:0]      sp_q;
  logic                 halted_q;
  logic                 stack_err_q;

  // Return stack contents are never reset; sp alone defines validity.
  logic [UADDR_W-1:0]   stack_q [STACK_DEPTH];

  logic [UADDR_W-1:0]   uaddr_inc;
  logic                 cond_hit;
  logic [SP_W-1:0]      sp_dec;
  logic [IDX_W-1:0]     push_idx;
  logic [IDX_W-1:0]     pop_idx;
  logic [UADDR_W-1:0]   stack_top;
  logic                 load_active;
  logic                 push_en;

  assign uaddr_inc = uaddr_q + ADDR_ONE;   // wraps modulo 2**UADDR_W
  assign cond_hit  = cond[seq_cond_sel] ^ seq_cond_inv;
  assign sp_dec    = sp_q - SP_ONE;
  assign push_idx  = sp_q[IDX_W-1:0];
  assign pop_idx   = sp_dec[IDX_W-1:0];
  assign stack_top = stack_q[pop_idx];

`ifdef UPGM_LOAD_EN
  // A load request, or the exit cycle from LOAD, pre-empts normal sequencing.
  assign load_active = load_req || (state_q == ST_LOAD);
`else
  assign load_active = 1'b0;
`endif

  assign push_en = !load_active && (state_q == ST_RUN) && !stall &&
                   (seq_op == OP_CALL) && (sp_q != SP_FULL);

  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_q[push_idx] <= uaddr_inc;
    end
  end

`ifdef UPGM_LOAD_EN
  logic              upgm_we_q;
  logic [UPGM_W-1:0] upgm_wdata_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_PRIME;
      uaddr_q      <= RESET_ADDR;
      sp_q         <= SP_EMPTY;
      halted_q     <= 1'b0;
      stack_err_q  <= 1'b0;
`ifdef UPGM_LOAD_EN
      upgm_we_q    <= 1'b0;
      upgm_wdata_q <= '0;
`endif
    end else begin
`ifdef UPGM_LOAD_EN
      if (load_req) begin
        state_q      <= ST_LOAD;
        uaddr_q      <= load_addr;
        upgm_we_q    <= 1'b1;
        upgm_wdata_q <= load_data;
        halted_q     <= 1'b0;
      end else if (state_q == ST_LOAD) begin
        // Program image may have changed; restart cleanly from RESET_VEC.
        upgm_we_q    <= 1'b0;
        sp_q         <= SP_EMPTY;
        uaddr_q      <= RESET_ADDR;
        state_q      <= ST_PRIME;
      end else
`endif
      begin
        case (state_q)
          // Hold uaddr one edge so the ROM has read it before execution.
          ST_PRIME: begin
            if (!stall) begin
              state_q <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (!stall) begin
              case (seq_op)
                OP_NEXT:     uaddr_q <= uaddr_inc;
                OP_JUMP:     uaddr_q <= seq_target;
                OP_CJMP:     uaddr_q <= cond_hit ? seq_target : uaddr_inc;
                OP_CALL: begin
                  // Overflow drops the return address but still branches.
                  if (sp_q == SP_FULL) begin
                    stack_err_q <= 1'b1;
                  end else begin
                    sp_q <= sp_q + SP_ONE;
                  end
                  uaddr_q <= seq_target;
                end
                OP_RET: begin
                  if (sp_q == SP_EMPTY) begin
                    uaddr_q     <= RESET_ADDR;
                    stack_err_q <= 1'b1;
                  end else begin
                    uaddr_q <= stack_top;
                    sp_q    <= sp_dec;
                  end
                end
                OP_DISPATCH: uaddr_q <= dispatch_addr;
                OP_WAIT:     uaddr_q <= cond_hit ? uaddr_inc : uaddr_q;
                OP_HALT: begin
                  state_q  <= ST_HALT;
                  halted_q <= 1'b1;
                end
                default:     uaddr_q <= uaddr_q;
              endcase
            end
          end
          ST_HALT: begin
            if (restart) begin
              uaddr_q  <= uaddr_inc;
              halted_q <= 1'b0;
              state_q  <= ST_PRIME;
            end
          end
          default: state_q <= ST_PRIME;
        endcase
      end
    end
  end

  assign uaddr     = uaddr_q;
  assign halted    = halted_q;
  assign stack_err = stack_err_q;

`ifdef UPGM_LOAD_EN
  assign upgm_we    = upgm_we_q;
  assign upgm_wdata = upgm_wdata_q;
`else
  assign upgm_we    = 1'b0;
  assign upgm_wdata = '0;
`endif

endmodule

// File: tb/tb_useq.sv
// ----------------------------------------------------------------------------
// Bench for useq. A queue-based behavioural model predicts uaddr, halted,
// stack_err and the ROM write outputs every cycle. A checker compares them on
// each negedge. Directed steps also pin literal addresses, followed by a
// randomized run.
// ----------------------------------------------------------------------------
module tb_useq;

  localparam int UADDR_W = 10;
  localparam int DEPTH   = 4;
  localparam int NCOND   = 16;
  localparam int UPGM_W  = 32;
  localparam int AMOD    = 1 << UADDR_W;

  logic                clk = 1'b0;
  logic                rst;
  logic [2:0]          seq_op;
  logic [UADDR_W-1:0]  seq_target;
  logic [3:0]          seq_cond_sel;
  logic                seq_cond_inv;
  logic [NCOND-1:0]    cond;
  logic [UADDR_W-1:0]  dispatch_addr;
  logic                stall;
  logic                restart;
  logic [UADDR_W-1:0]  uaddr;
  logic                upgm_we;
  logic [UPGM_W-1:0]   upgm_wdata;
  logic                halted;
  logic                stack_err;
`ifdef UPGM_LOAD_EN
  logic                load_req;
  logic [UADDR_W-1:0]  load_addr;
  logic [UPGM_W-1:0]   load_data;
`endif

  useq #(.UADDR_W(UADDR_W), .STACK_DEPTH(DEPTH), .NCOND(NCOND),
         .RESET_VEC(0), .UPGM_W(UPGM_W)) dut (
    .clk(clk), .rst(rst), .seq_op(seq_op), .seq_target(seq_target),
    .seq_cond_sel(seq_cond_sel), .seq_cond_inv(seq_cond_inv), .cond(cond),
    .dispatch_addr(dispatch_addr), .stall(stall), .restart(restart),
`ifdef UPGM_LOAD_EN
    .load_req(load_req), .load_addr(load_addr), .load_data(load_data),
`endif
    .uaddr(uaddr), .upgm_we(upgm_we), .upgm_wdata(upgm_wdata),
    .halted(halted), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // ---------------- behavioural model ----------------
  localparam int M_PRIME = 0, M_RUN = 1, M_HALT = 2, M_LOAD = 3;
  int          m_mode;
  int          m_uaddr;
  int          m_stack[$];
  bit          m_err, m_halt, m_we, m_c;
  int unsigned m_wdata;

  task automatic model_step();
    m_c = cond[seq_cond_sel] ^ seq_cond_inv;
    if (m_mode == M_PRIME) begin
      if (!stall) m_mode = M_RUN;
    end else if (m_mode == M_RUN && !stall) begin
      case (seq_op)
        3'd0: m_uaddr = (m_uaddr + 1) % AMOD;
        3'd1: m_uaddr = int'(seq_target);
        3'd2: m_uaddr = m_c ? int'(seq_target) : (m_uaddr + 1) % AMOD;
        3'd3: begin
          if (m_stack.size() < DEPTH) m_stack.push_back((m_uaddr + 1) % AMOD);
          else m_err = 1'b1;
          m_uaddr = int'(seq_target);
        end
        3'd4: begin
          if (m_stack.size() == 0) begin
            m_uaddr = 0;
            m_err = 1'b1;
          end else begin
            m_uaddr = m_stack.pop_back();
          end
        end
        3'd5: m_uaddr = int'(dispatch_addr);
        3'd6: if (m_c) m_uaddr = (m_uaddr + 1) % AMOD;
        default: begin
          m_halt = 1'b1;
          m_mode = M_HALT;
        end
      endcase
    end else if (m_mode == M_HALT && restart) begin
      m_uaddr = (m_uaddr + 1) % AMOD;
      m_halt  = 1'b0;
      m_mode  = M_PRIME;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_mode = M_PRIME; m_uaddr = 0; m_stack.delete();
        m_err = 0; m_halt = 0; m_we = 0; m_wdata = 0;
      end else begin
`ifdef UPGM_LOAD_EN
        if (load_req) begin
          m_mode = M_LOAD; m_uaddr = int'(load_addr); m_we = 1'b1;
          m_wdata = load_data; m_halt = 1'b0;
        end else if (m_mode == M_LOAD) begin
          m_we = 1'b0; m_stack.delete(); m_uaddr = 0; m_mode = M_PRIME;
        end else
`endif
        model_step();
      end
    end
  end

  // ---------------- compare ----------------
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && !rst) begin
        check("uaddr", 32'(uaddr), 32'(m_uaddr));
        check("halted", 32'(halted), 32'(m_halt));
        check("stack_err", 32'(stack_err), 32'(m_err));
        check("upgm_we", 32'(upgm_we), 32'(m_we));
        check("upgm_wdata", 32'(upgm_wdata), m_wdata);
      end
    end
  end

  // Literal expectation, hand-computed; one line per directed transaction.
  task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
    $display("txn %s uaddr=%03h halted=%0d err=%0d", nm, uaddr, halted, stack_err);
    check(nm, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] o, input logic [UADDR_W-1:0] t);
    seq_op = o;
    seq_target = t;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; seq_op = 3'd0; seq_target = '0; seq_cond_sel = '0;
    seq_cond_inv = 1'b0; cond = '0; dispatch_addr = '0; stall = 1'b0;
    restart = 1'b0;
`ifdef UPGM_LOAD_EN
    load_req = 1'b0; load_addr = '0; load_data = '0;
`endif
    tick(); tick();
    lit("rst_uaddr", 32'(uaddr), 32'h0);
    lit("rst_halted", 32'(halted), 32'h0);
    lit("rst_err", 32'(stack_err), 32'h0);
    chk_en = 1'b1;

    // NEXT x3 after the prime cycle
    rst = 1'b0;
    op(3'd0, '0); lit("prime_hold", 32'(uaddr), 32'h0);
    op(3'd0, '0); lit("next1", 32'(uaddr), 32'h1);
    op(3'd0, '0); lit("next2", 32'(uaddr), 32'h2);
    op(3'd0, '0); lit("next3", 32'(uaddr), 32'h3);

    // CJMP variants at 0x005
    op(3'd1, 10'h005); lit("jump5", 32'(uaddr), 32'h5);
    seq_cond_sel = 4'd3; cond = 16'h0008;
    op(3'd2, 10'h040); lit("cjmp_taken", 32'(uaddr), 32'h40);
    op(3'd1, 10'h005); cond = 16'h0000;
    op(3'd2, 10'h040); lit("cjmp_fall", 32'(uaddr), 32'h6);
    op(3'd1, 10'h005); seq_cond_inv = 1'b1;
    op(3'd2, 10'h040); lit("cjmp_inv", 32'(uaddr), 32'h40);
    seq_cond_inv = 1'b0;

    // nested CALL/RET
    op(3'd1, 10'h010);
    op(3'd3, 10'h100); lit("call1", 32'(uaddr), 32'h100);
    op(3'd3, 10'h200); lit("call2", 32'(uaddr), 32'h200);
    op(3'd4, '0);      lit("ret1", 32'(uaddr), 32'h101);
    op(3'd4, '0);      lit("ret2", 32'(uaddr), 32'h011);
    lit("ret_noerr", 32'(stack_err), 32'h0);

    // WAIT spin
    op(3'd1, 10'h020); seq_cond_sel = 4'd0; cond = 16'h0000;
    repeat (4) begin op(3'd6, '0); lit("wait_spin", 32'(uaddr), 32'h20); end
    cond = 16'h0001;
    op(3'd6, '0); lit("wait_go", 32'(uaddr), 32'h21);

    // stall during JUMP
    stall = 1'b1;
    repeat (3) begin op(3'd1, 10'h123); lit("stall_hold", 32'(uaddr), 32'h21); end
    stall = 1'b0;
    op(3'd1, 10'h123); lit("stall_release", 32'(uaddr), 32'h123);

    dispatch_addr = 10'h2AB;
    op(3'd5, '0); lit("dispatch", 32'(uaddr), 32'h2AB);

    // wrap
    op(3'd1, 10'h3FF);
    op(3'd0, '0); lit("wrap", 32'(uaddr), 32'h0);

    // overflow: DEPTH+1 nested calls from 0
    for (int i = 0; i <= DEPTH; i++) op(3'd3, 10'(10'h030 + i));
    lit("ovf_err", 32'(stack_err), 32'h1);
    lit("ovf_addr", 32'(uaddr), 32'h34);
    op(3'd4, '0); lit("ovf_ret1", 32'(uaddr), 32'h33);
    repeat (3) op(3'd4, '0);
    lit("ovf_ret4", 32'(uaddr), 32'h1);

    // underflow
    rst = 1'b1; tick(); lit("err_cleared", 32'(stack_err), 32'h0);
    rst = 1'b0; op(3'd0, '0);
    op(3'd1, 10'h077);
    op(3'd4, '0); lit("unf_addr", 32'(uaddr), 32'h0);
    lit("unf_err", 32'(stack_err), 32'h1);

    // HALT, frozen, restart
    op(3'd1, 10'h050);
    op(3'd7, '0); lit("halt_addr", 32'(uaddr), 32'h50);
    lit("halt_flag", 32'(halted), 32'h1);
    repeat (10) begin
      seq_op = 3'($urandom_range(0, 7)); stall = 1'($urandom_range(0, 1));
      seq_target = 10'($urandom);
      tick(); lit("halt_frozen", 32'(uaddr), 32'h50);
    end
    stall = 1'b0; restart = 1'b1;
    tick(); lit("restart_addr", 32'(uaddr), 32'h51);
    lit("restart_flag", 32'(halted), 32'h0);
    restart = 1'b0;
    op(3'd0, '0); lit("restart_prime", 32'(uaddr), 32'h51);
    op(3'd0, '0); lit("restart_exec", 32'(uaddr), 32'h52);

    // reset mid-CALL
    op(3'd3, 10'h180);
    seq_op = 3'd3; seq_target = 10'h1C0; rst = 1'b1;
    #1 lit("rst_mid_call", 32'(uaddr), 32'h0);
    tick(); rst = 1'b0;
    op(3'd0, '0);
    op(3'd1, 10'h099);
    op(3'd4, '0); lit("rst_sp0", 32'(uaddr), 32'h0);
    lit("rst_sp0_err", 32'(stack_err), 32'h1);

`ifdef UPGM_LOAD_EN
    stall = 1'b1; load_req = 1'b1; load_addr = 10'h007; load_data = 32'hABC;
    tick(); lit("load_we", 32'(upgm_we), 32'h1);
    lit("load_addr", 32'(uaddr), 32'h7);
    lit("load_data", upgm_wdata, 32'hABC);
    stall = 1'b0; load_req = 1'b0;
    tick(); lit("load_exit_we", 32'(upgm_we), 32'h0);
    lit("load_exit_addr", 32'(uaddr), 32'h0);
    op(3'd0, '0); lit("load_prime", 32'(uaddr), 32'h0);
    op(3'd0, '0); lit("load_exec", 32'(uaddr), 32'h1);
`endif

    // randomized run
    for (int n = 0; n < 3000; n++) begin
      seq_op        = 3'($urandom_range(0, 7));
      seq_target    = 10'($urandom);
      seq_cond_sel  = 4'($urandom);
      seq_cond_inv  = 1'($urandom);
      cond          = 16'($urandom);
      dispatch_addr = 10'($urandom);
      stall         = ($urandom_range(0, 4) == 0);
      restart       = ($urandom_range(0, 7) == 0);
      rst           = ($urandom_range(0, 199) == 0);
`ifdef UPGM_LOAD_EN
      load_req      = ($urandom_range(0, 49) == 0);
      load_addr     = 10'($urandom);
      load_data     = $urandom;
`endif
      tick();
    end
    rst = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/useq.md
Name: useq

Overview:
- Microsequencer feeding the uProgram ROM's `addr` port and consuming its `data` word. This is the ROM's direct upstream/downstream neighbour.
- Holds the micro-PC and executes the sequencing field of the current microword: next, jump, conditional jump, call/return, opcode dispatch, wait, halt.
- Return addresses live on a small hardware stack.
- Next address is computed and registered on posedge clk. The ROM reads on negedge clk, so one microinstruction executes per clock.

Parameters:
- UADDR_W, 10: micro-address width; equals $bits(uaddr_t).
- STACK_DEPTH, 4: return-stack entries, 1..16.
- NCOND, 16: condition inputs; sel width is $clog2(NCOND).
- RESET_VEC, 0: micro-address loaded on reset and on stack underflow.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- seq_op  in  3  sequencing opcode from the current ROM word.
- seq_target  in  UADDR_W  branch/call target from the ROM word.
- seq_cond_sel  in  $clog2(NCOND)  index into cond.
- seq_cond_inv  in  1  invert the selected condition.
- cond  in  NCOND  live datapath condition flags.
- dispatch_addr  in  UADDR_W  entry address from the opcode map.
- stall  in  1  hold the entire sequencer this cycle.
- restart  in  1  leave HALT.
- uaddr  out  UADDR_W  micro-address to the ROM.
- upgm_we  out  1  ROM write enable.
- upgm_wdata  out  $bits(upgm_t)  ROM write data.
- halted  out  1  high in HALT.
- stack_err  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset (async assert, held):
  - uaddr=RESET_VEC, sp=0, stack_err=0, halted=0, upgm_we=0, upgm_wdata=0.
  - State=PRIME.
- PRIME:
  - Lasts exactly one posedge after reset deasserts; uaddr holds.
  - Guarantees the ROM has completed a negedge read of RESET_VEC before the first execute.
  - Then goes to RUN.
- RUN, when stall=0. c = cond[seq_cond_sel] ^ seq_cond_inv. Next uaddr by seq_op:
  - 0 NEXT: uaddr+1, wrapping modulo 2**UADDR_W.
  - 1 JUMP: seq_target.
  - 2 CJMP: c ? seq_target : uaddr+1.
  - 3 CALL: push uaddr+1, go to seq_target. If sp==STACK_DEPTH: push discarded, stack_err<=1, jump still taken.
  - 4 RET: pop; uaddr=top, sp-1. If sp==0: uaddr=RESET_VEC, stack_err<=1.
  - 5 DISPATCH: dispatch_addr.
  - 6 WAIT: c ? uaddr+1 : uaddr (spin in place).
  - 7 HALT: uaddr holds, state=HALT, halted=1 registered the same edge.
- stall=1: no state, uaddr, sp or flag changes. stall has priority over everything except rst.
- HALT:
  - uaddr frozen.
  - restart=1 at a posedge: uaddr<=uaddr+1, halted<=0, state=PRIME (one prime cycle before executing).
  - stall is ignored in HALT.
- Registered outputs: uaddr is a registered output; its new value appears after the posedge. The ROM samples it on the following negedge. Latency from ROM word to new address: one posedge.
- Stack: LIFO, STACK_DEPTH x UADDR_W, entries not cleared on reset. stack_err clears only on rst.
- Reset mid-operation forces PRIME regardless of state or stall.

Optional Feature:
- Macro: UPGM_LOAD_EN.
- When defined, adds ports load_req in 1, load_addr in UADDR_W, load_data in $bits(upgm_t), plus state LOAD.
- Entering LOAD: any state except reset goes to LOAD at the posedge where load_req=1. load_req has priority over stall.
- In LOAD: uaddr=load_addr, upgm_we=load_req, upgm_wdata=load_data, registered. The ROM writes on the following negedge.
- Leaving LOAD: on load_req=0, upgm_we<=0, sp<=0, uaddr<=RESET_VEC, state=PRIME.
- When not defined: no extra ports; upgm_we and upgm_wdata tied 0; LOAD state absent.

Test Plan:
- Reset, then ROM words NEXT x3 -> uaddr 0 held for the PRIME cycle, then 1, 2, 3 on successive posedges.
- Word at 0x005 = CJMP target 0x040, sel 3, inv 0, with cond[3]=1 -> uaddr 0x040; repeat with cond[3]=0 -> 0x006; inv=1 with cond[3]=0 -> 0x040.
- Nested CALL 0x100 from 0x010, CALL 0x200 from 0x100, RET, RET -> uaddr 0x100, 0x200, 0x101, 0x011. STACK_DEPTH+1 nested CALLs -> stack_err=1, last push lost. RET with sp=0 -> uaddr=RESET_VEC, stack_err=1.
- WAIT at 0x020 with cond[0]=0 for 4 cycles, then 1 -> uaddr stays 0x020 for 4 cycles, then 0x021. stall=1 during a JUMP -> uaddr unchanged until stall drops.
- NEXT at 0x3FF (UADDR_W=10) -> uaddr 0x000. HALT at 0x050 -> halted=1, uaddr 0x050 frozen 10 cycles. restart -> one PRIME cycle at 0x051, then execution. rst mid-CALL -> uaddr=0, sp=0.
- With UPGM_LOAD_EN: load_req with addr 0x007, data 0xABC -> upgm_we=1, uaddr=0x007. Drop load_req -> PRIME at 0, then execution reads the written word.
